// File: rtl/status_led_arbiter.sv
// Round-robin owner of one status LED; the granted requester's code is shown as
// n pulses followed by a dark gap, all phases timed in prescaled ticks.
//
// state | meaning
// IDLE  | arbitrating; led dark, busy low
// ON    | pulse lit, ON_TICKS ticks
// OFF   | dark between pulses, OFF_TICKS ticks
// GAP   | dark after last pulse, GAP_TICKS ticks
module status_led_arbiter #(
   parameter int CLOCK_FREQ_HZ = 50_000_000,
   parameter int TICK_HZ       = 10,
   parameter int NUM_REQ       = 4,
   parameter int CODE_W        = 4,
   parameter int ON_TICKS      = 2,
   parameter int OFF_TICKS     = 3,
   parameter int GAP_TICKS     = 10,
   localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*CODE_W-1:0] code_i,
   input  logic                      abort_i,
   output logic [NUM_REQ-1:0]        ack_o,
   output logic                      busy_o,
   output logic [IDX_W-1:0]          active_o,
   output logic                      led_o
);

   localparam int TICK_DIV = (TICK_HZ > 0) ? CLOCK_FREQ_HZ / TICK_HZ : 1;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PH_MAX0  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int PH_MAX   = ((PH_MAX0 > GAP_TICKS) ? PH_MAX0 : GAP_TICKS) - 1;
   localparam int PH_W     = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;

   localparam logic [PRE_W-1:0] PRE_TC  = PRE_W'(TICK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_ON   = PH_W'(ON_TICKS - 1);
   localparam logic [PH_W-1:0]  PH_OFF  = PH_W'(OFF_TICKS - 1);
   localparam logic [PH_W-1:0]  PH_GAP  = PH_W'(GAP_TICKS - 1);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_REQ - 1);

   if (TICK_HZ <= 0 || CLOCK_FREQ_HZ < TICK_HZ) begin : g_chk_tick
      $error("status_led_arbiter: need TICK_HZ > 0 and CLOCK_FREQ_HZ >= TICK_HZ");
   end
   if (NUM_REQ < 1) begin : g_chk_req
      $error("status_led_arbiter: NUM_REQ must be >= 1");
   end
   if (ON_TICKS < 1 || OFF_TICKS < 1 || GAP_TICKS < 1) begin : g_chk_ticks
      $error("status_led_arbiter: ON/OFF/GAP_TICKS must each be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

   state_t             r_state,  w_state_nxt;
   logic [PRE_W-1:0]   r_pre,    w_pre_nxt;
   logic [PH_W-1:0]    r_ph,     w_ph_nxt;
   logic [CODE_W-1:0]  r_rem,    w_rem_nxt;
   logic [IDX_W-1:0]   r_ptr,    w_ptr_nxt;
   logic [IDX_W-1:0]   r_active, w_active_nxt;
   logic [NUM_REQ-1:0] r_ack,    w_ack_nxt;

   logic               w_tick;
   logic               w_ph_end;
   logic               w_hit;
   logic [IDX_W-1:0]   w_gidx;
   logic [CODE_W-1:0]  w_code;

   assign w_tick   = (r_pre == PRE_TC);
   assign w_ph_end = w_tick && (r_ph == '0);

   // Walk downward from the farthest candidate so the one nearest ptr wins.
   always_comb begin : p_arb
      int idx;
      idx    = 0;
      w_hit  = 1'b0;
      w_gidx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(r_ptr) + k) % NUM_REQ;
         if (req_i[idx]) begin
            w_hit  = 1'b1;
            w_gidx = IDX_W'(idx);
         end
      end
   end

   assign w_code = code_i[int'(w_gidx)*CODE_W +: CODE_W];

   always_comb begin
      w_state_nxt  = r_state;
      w_pre_nxt    = w_tick ? '0 : r_pre + 1'b1;
      w_ph_nxt     = r_ph;
      w_rem_nxt    = r_rem;
      w_ptr_nxt    = r_ptr;
      w_active_nxt = r_active;
      w_ack_nxt    = '0;
      if (r_state != S_IDLE && abort_i) begin
         w_state_nxt = S_IDLE;
         w_ph_nxt    = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  w_ack_nxt    = NUM_REQ'(1) << w_gidx;
                  w_active_nxt = w_gidx;
                  w_rem_nxt    = w_code;
                  w_ptr_nxt    = (w_gidx == IDX_TOP) ? '0 : w_gidx + 1'b1;
                  w_pre_nxt    = '0;
                  w_ph_nxt     = PH_ON;
                  if (w_code != '0) w_state_nxt = S_ON;
               end
            end
            S_ON: begin
               if (w_ph_end) begin
                  w_rem_nxt = r_rem - 1'b1;
                  if (r_rem == CODE_W'(1)) begin
                     w_state_nxt = S_GAP;
                     w_ph_nxt    = PH_GAP;
                  end else begin
                     w_state_nxt = S_OFF;
                     w_ph_nxt    = PH_OFF;
                  end
               end else if (w_tick) begin
                  w_ph_nxt = r_ph - 1'b1;
               end
            end
            S_OFF: begin
               if (w_ph_end) begin
                  w_state_nxt = S_ON;
                  w_ph_nxt    = PH_ON;
               end else if (w_tick) begin
                  w_ph_nxt = r_ph - 1'b1;
               end
            end
            S_GAP: begin
               if (w_ph_end) begin
                  w_state_nxt = S_IDLE;
               end else if (w_tick) begin
                  w_ph_nxt = r_ph - 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_pre    <= '0;
         r_ph     <= '0;
         r_rem    <= '0;
         r_ptr    <= '0;
         r_active <= '0;
         r_ack    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_pre    <= w_pre_nxt;
         r_ph     <= w_ph_nxt;
         r_rem    <= w_rem_nxt;
         r_ptr    <= w_ptr_nxt;
         r_active <= w_active_nxt;
         r_ack    <= w_ack_nxt;
      end
   end

   assign led_o    = (r_state == S_ON);
   assign busy_o   = (r_state != S_IDLE);
   assign ack_o    = r_ack;
   assign active_o = r_active;

endmodule

// File: tb/tb_status_led_arbiter.sv
// Directed bench for status_led_arbiter: single code, round robin, zero code,
// abort, reset mid-code and a request arriving during the gap.
module tb_status_led_arbiter;

   localparam int NUM_REQ = 4;
   localparam int CODE_W  = 4;
   localparam int DIV     = 2;
   localparam int ONC     = 2 * DIV;
   localparam int OFFC    = 3 * DIV;
   localparam int GAPC    = 4 * DIV;

   logic                      clk_i = 1'b0;
   logic                      rst_ni;
   logic [NUM_REQ-1:0]        req_i;
   logic [NUM_REQ*CODE_W-1:0] code_i;
   logic                      abort_i;
   logic [NUM_REQ-1:0]        ack_o;
   logic                      busy_o;
   logic [1:0]                active_o;
   logic                      led_o;

   int n_chk  = 0;
   int n_fail = 0;

   status_led_arbiter #(
      .CLOCK_FREQ_HZ (20),
      .TICK_HZ       (10),
      .NUM_REQ       (NUM_REQ),
      .CODE_W        (CODE_W),
      .ON_TICKS      (2),
      .OFF_TICKS     (3),
      .GAP_TICKS     (4)
   ) u_dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_i    (req_i),
      .code_i   (code_i),
      .abort_i  (abort_i),
      .ack_o    (ack_o),
      .busy_o   (busy_o),
      .active_o (active_o),
      .led_o    (led_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic int code_len(input int n);
      return n * ONC + (n - 1) * OFFC + GAPC;
   endfunction

   // Cycle c counts from 0 at the first sample after the grant edge.
   function automatic logic exp_led(input int n, input int c);
      return (c < code_len(n) - GAPC) && ((c % (ONC + OFFC)) < ONC);
   endfunction

   task automatic do_reset();
      rst_ni  = 1'b0;
      req_i   = '0;
      code_i  = '0;
      abort_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check_val("rst_led", 32'(led_o), 0);
      check_val("rst_busy", 32'(busy_o), 0);
      check_val("rst_ack", 32'(ack_o), 0);
      check_val("rst_active", 32'(active_o), 0);
      rst_ni = 1'b1;
   endtask

   task automatic watch_code(input int n, input int idx, input bit drop);
      int len;
      len = code_len(n);
      for (int c = 0; c <= len; c++) begin
         @(negedge clk_i);
         if (c == 0) begin
            check_val($sformatf("ack_grant%0d", idx), 32'(ack_o), 32'(1 << idx));
            check_val($sformatf("active_grant%0d", idx), 32'(active_o), 32'(idx));
            if (drop) req_i[idx] = 1'b0;
         end else if (c == 1) begin
            check_val("ack_one_cycle", 32'(ack_o), 0);
         end
         check_val($sformatf("led n=%0d c=%0d", n, c), 32'(led_o), 32'(exp_led(n, c)));
         check_val($sformatf("busy n=%0d c=%0d", n, c), 32'(busy_o), 32'(c < len));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      do_reset();

      // single code 3 on requester 0
      req_i[0] = 1'b1;
      code_i[3:0] = 4'd3;
      watch_code(3, 0, 1'b1);
      @(negedge clk_i);
      check_val("single_no_regrant", 32'(ack_o), 0);

      // round robin between 0 and 2, both held
      do_reset();
      code_i[3:0]  = 4'd1;
      code_i[11:8] = 4'd1;
      req_i[0] = 1'b1;
      req_i[2] = 1'b1;
      watch_code(1, 0, 1'b0);
      watch_code(1, 2, 1'b0);
      watch_code(1, 0, 1'b0);
      watch_code(1, 2, 1'b0);
      req_i = '0;

      // zero code on 1, then 2 on the following cycle
      do_reset();
      req_i[1] = 1'b1;
      code_i[7:4] = 4'd0;
      req_i[2] = 1'b1;
      code_i[11:8] = 4'd1;
      @(negedge clk_i);
      check_val("zero_ack", 32'(ack_o), 32'h2);
      check_val("zero_led", 32'(led_o), 0);
      check_val("zero_busy", 32'(busy_o), 0);
      check_val("zero_active", 32'(active_o), 1);
      req_i[1] = 1'b0;
      watch_code(1, 2, 1'b1);

      // abort in the 5th ON cycle of a code-2 run, pending request on 3
      do_reset();
      req_i[0] = 1'b1;
      code_i[3:0] = 4'd2;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk_i);
         if (c == 0) begin
            check_val("abort_grant", 32'(ack_o), 32'h1);
            req_i[0] = 1'b0;
         end
         check_val($sformatf("abort_led c=%0d", c), 32'(led_o), 32'(exp_led(2, c)));
      end
      abort_i = 1'b1;
      req_i[3] = 1'b1;
      code_i[15:12] = 4'd1;
      @(negedge clk_i);
      check_val("abort_led_off", 32'(led_o), 0);
      check_val("abort_busy_off", 32'(busy_o), 0);
      check_val("abort_no_ack", 32'(ack_o), 0);
      abort_i = 1'b0;
      @(negedge clk_i);
      check_val("abort_next_ack", 32'(ack_o), 32'h8);
      check_val("abort_next_active", 32'(active_o), 3);
      check_val("abort_next_led", 32'(led_o), 1);
      req_i = '0;

      // asynchronous reset during OFF; ptr must return to 0
      do_reset();
      req_i[1] = 1'b1;
      code_i[7:4] = 4'd2;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk_i);
         if (c == 0) begin
            check_val("mid_grant", 32'(ack_o), 32'h2);
            req_i[1] = 1'b0;
            req_i[0] = 1'b1;
            req_i[3] = 1'b1;
            code_i[3:0]   = 4'd1;
            code_i[15:12] = 4'd1;
         end
      end
      check_val("mid_off_led", 32'(led_o), 0);
      check_val("mid_off_busy", 32'(busy_o), 1);
      #2 rst_ni = 1'b0;
      #1;
      check_val("mid_rst_busy", 32'(busy_o), 0);
      check_val("mid_rst_led", 32'(led_o), 0);
      check_val("mid_rst_ack", 32'(ack_o), 0);
      check_val("mid_rst_active", 32'(active_o), 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_val("mid_post_ack", 32'(ack_o), 32'h1);
      check_val("mid_post_active", 32'(active_o), 0);
      check_val("mid_post_led", 32'(led_o), 1);
      req_i = '0;

      // request on 1 arriving during GAP waits for the IDLE cycle
      do_reset();
      req_i[0] = 1'b1;
      code_i[3:0] = 4'd1;
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk_i);
         if (c == 0) begin
            check_val("late_first", 32'(ack_o), 32'h1);
            req_i[0] = 1'b0;
         end else if (c <= 12) begin
            check_val($sformatf("late_ack c=%0d", c), 32'(ack_o), 0);
            check_val($sformatf("late_busy c=%0d", c), 32'(busy_o), 32'(c < 12));
         end else begin
            check_val("late_ack", 32'(ack_o), 32'h2);
            check_val("late_led", 32'(led_o), 1);
            check_val("late_busy", 32'(busy_o), 1);
         end
         if (c == 6) begin
            req_i[1] = 1'b1;
            code_i[7:4] = 4'd2;
         end
      end
      req_i = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
